jogo_memoria_param: RTL and testbench
=====================================

Name: jogo_memoria_param

Overview:
Parametrised successor to the fixed 4-button, 16-round memory-game datapath/control pair; one self-contained core.
- Stores the sequence, plays it back on the LEDs with timed on/off phases, and checks player presses.
- The player appends one new move per round.
- Adds configurable button count, round count, LED timing, optional timeout, and a short-game mode.
- Sits between debounced board buttons and LED/7-segment debug drivers.

Parameters:
N_BOTOES, 4, number of buttons/LEDs (2..8); one-hot on the ports.
N_RODADAS, 16, rounds needed to win (power of 2, 2..64).
T_LED, 1000, clock cycles an LED stays lit during playback.
T_APAGADO, 500, clock cycles all LEDs are dark between playback steps.
T_TIMEOUT, 5000, idle cycles allowed while waiting for a press.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; forces INICIAL.
jogar  in  1  level; 0->1 edge starts or restarts a game.
modo  in  2  sampled at the jogar edge; bit0 = timeout enable; bit1 = short game (goal N_RODADAS/2).
botoes  in  N_BOTOES  debounced buttons, active-high.
leds  out  N_BOTOES  one-hot playback or echo of the current press.
pronto  out  1  high in any final state.
ganhou  out  1  win.
perdeu  out  1  wrong move or timeout.
timeout  out  1  loss caused by timeout.
db_estado  out  5  current state code.
db_rodada  out  clog2(N_RODADAS)+1  current round index.
db_igual  out  1  last compare matched.

Behaviour:
- Reset: all outputs 0; state INICIAL; round counter, address counter and timers 0. Memory contents are not cleared.
- Memory: N_RODADAS x clog2(N_BOTOES). Synchronous write; combinational read at the address counter.
- Press detect: rising edge of |botoes, registered one cycle.
  - Exactly one bit set: encode to an index.
  - More than one bit set: invalid; treated as a mismatch.
  - Releasing the button generates no event.
- Entry 0: at the jogar edge, a free-running mod-N_BOTOES counter value is written to address 0.
- State flow:
  - INICIAL -> PREPARA on the jogar edge. PREPARA latches modo and sets round = 0, address = 0.
  - MOSTRA_LED: leds = onehot(mem[addr]) for T_LED cycles.
  - APAGA_LED: leds = 0 for T_APAGADO cycles.
  - After APAGA_LED: if addr == round -> ESPERA_JOGADA with addr = 0; else addr++ and back to MOSTRA_LED.
  - ESPERA_JOGADA: wait for a press event.
  - COMPARA, 1 cycle:
    - Mismatch -> FINAL_ERRO.
    - Match and addr < round -> addr++, back to ESPERA_JOGADA.
    - Match and addr == round and round == goal-1 -> FINAL_ACERTO.
    - Otherwise -> ADICIONA_JOGADA.
  - ADICIONA_JOGADA: wait for a press. A valid press writes mem[round+1] -> PROX_RODADA. An invalid press -> FINAL_ERRO.
  - PROX_RODADA: round++, addr = 0 -> MOSTRA_LED.
- Echo: during ESPERA_JOGADA and ADICIONA_JOGADA, leds = botoes.
- Timeout:
  - Counter clears on entry to ESPERA_JOGADA or ADICIONA_JOGADA and on every press event.
  - If modo[0] = 1 and the count reaches T_TIMEOUT-1 -> FINAL_TIMEOUT.
  - A press arriving in the same cycle as expiry wins over the timeout.
- Final states:
  - FINAL_ACERTO: pronto = ganhou = 1.
  - FINAL_ERRO: pronto = perdeu = 1.
  - FINAL_TIMEOUT: pronto = perdeu = timeout = 1.
  - All three hold until the next jogar edge -> PREPARA. Outputs clear on that transition.
- Mid-game: a jogar edge mid-game is ignored. An async reset mid-game returns to INICIAL immediately.

Optional Feature:
Macro JOGO_VIDA_EXTRA_EN.
- Defined: one extra life per game. The first mismatch or timeout goes to state PERDE_VIDA instead of a final state.
  - PERDE_VIDA lights all LEDs for T_LED cycles, sets addr = 0, then replays the current round from MOSTRA_LED.
  - The second fault ends the game as normal.
  - The life flag is visible as db_estado bit pattern 5'b10101 while in PERDE_VIDA.
- Undefined: the state and flag are absent; the first fault is final.

Decomposition:
- Package jogo_memoria_pkg: the state enum with 5-bit codes fixed for db_estado, plus the clog2 helper function.
- Sub-module detector_jogada: edge detect, one-hot validity check, one-hot to index encode, 1-cycle registered event output.

Test Plan:
- Win, modo=00, N_BOTOES=4, N_RODADAS=16: after jogar, press the correct replay and append 0001,0010,0100,1000 repeating -> ganhou=1, pronto=1 after round 16, db_rodada=15.
- Short game, modo=10: same stimulus -> ganhou=1 after 8 rounds; ganhou never asserts before that.
- Wrong move in round 3: press 0100 where 0010 is expected -> perdeu=1, timeout=0, FINAL_ERRO within 2 cycles of the press event.
- Timeout, modo=01: no press after round 1 playback -> timeout=perdeu=1 exactly T_TIMEOUT cycles after entering ESPERA_JOGADA. The same idle with modo=00 never times out.
- Invalid press: botoes=0011 in ESPERA_JOGADA -> FINAL_ERRO. Then reset pulse mid-playback -> all outputs 0, db_estado = INICIAL.
- JOGO_VIDA_EXTRA_EN defined: first wrong move -> all LEDs lit for T_LED cycles, round replayed. Second wrong move -> perdeu=1.

Source files
------------

// File: rtl/jogo_memoria_pkg.sv
// Shared state codes and width helper for the parametrised memory game.
// The optional extra-life state (JOGO_VIDA_EXTRA_EN) keeps its code here in all builds.
package jogo_memoria_pkg;

  // Codes are exported on db_estado and must stay fixed.
  localparam logic [4:0] StInicial       = 5'h00;
  localparam logic [4:0] StPrepara       = 5'h01;
  localparam logic [4:0] StMostraLed     = 5'h02;
  localparam logic [4:0] StApagaLed      = 5'h03;
  localparam logic [4:0] StEsperaJogada  = 5'h04;
  localparam logic [4:0] StCompara       = 5'h05;
  localparam logic [4:0] StAdicionaJogada = 5'h06;
  localparam logic [4:0] StProxRodada    = 5'h07;
  localparam logic [4:0] StFinalAcerto   = 5'h08;
  localparam logic [4:0] StFinalErro     = 5'h09;
  localparam logic [4:0] StFinalTimeout  = 5'h0A;
  localparam logic [4:0] StPerdeVida     = 5'h15;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jogo_memoria_param_detector_jogada.sv
// Press detector: rising edge of any button, one-hot check and index encode,
// presented as a single registered event cycle.
module detector_jogada
  import jogo_memoria_pkg::*;
#(
  parameter int unsigned N_BOTOES = 4,
  parameter int unsigned IW       = clog2(N_BOTOES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_BOTOES-1:0] botoes_i,
  output logic                evento_o,
  output logic                valido_o,
  output logic [IW-1:0]       indice_o
);

  localparam logic [N_BOTOES-1:0] Um = 1;

  logic          algum_q;
  logic          evento_q;
  logic          valido_q;
  logic [IW-1:0] indice_q;

  logic          algum;
  logic          subida;
  logic          um_so;
  logic [IW-1:0] indice;

  always_comb begin
    algum  = |botoes_i;
    subida = algum & ~algum_q;
    // Clearing the lowest set bit leaves zero only for a single-bit pattern.
    um_so  = algum && ((botoes_i & (botoes_i - Um)) == '0);
    indice = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (botoes_i[i]) indice = IW'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      algum_q  <= 1'b0;
      evento_q <= 1'b0;
      valido_q <= 1'b0;
      indice_q <= '0;
    end else begin
      algum_q  <= algum;
      evento_q <= subida;
      valido_q <= um_so;
      indice_q <= indice;
    end
  end

  assign evento_o = evento_q;
  assign valido_o = valido_q;
  assign indice_o = indice_q;

endmodule

// File: rtl/jogo_memoria_param.sv
// Parametrised memory game core: stores, plays back and checks a growing move sequence.
// Define JOGO_VIDA_EXTRA_EN to grant one extra life per game (state PerdeVida).
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int unsigned N_BOTOES  = 4,
  parameter int unsigned N_RODADAS = 16,
  parameter int unsigned T_LED     = 1000,
  parameter int unsigned T_APAGADO = 500,
  parameter int unsigned T_TIMEOUT = 5000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        jogar,
  input  logic [1:0]                  modo,
  input  logic [N_BOTOES-1:0]         botoes,
  output logic [N_BOTOES-1:0]         leds,
  output logic                        pronto,
  output logic                        ganhou,
  output logic                        perdeu,
  output logic                        timeout,
  output logic [4:0]                  db_estado,
  output logic [clog2(N_RODADAS):0]   db_rodada,
  output logic                        db_igual
);

  localparam int unsigned IW    = clog2(N_BOTOES);
  localparam int unsigned AW    = clog2(N_RODADAS);
  localparam int unsigned RW    = AW + 1;
  localparam int unsigned TMax1 = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
  localparam int unsigned TMax  = (TMax1 > T_TIMEOUT) ? TMax1 : T_TIMEOUT;
  localparam int unsigned TW    = clog2(TMax) + 1;
  localparam logic [N_BOTOES-1:0] Um = 1;

  logic [4:0]    estado_q, estado_d;
  logic [RW-1:0] rodada_q, rodada_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    modo_q, modo_d;
  logic          igual_q, igual_d;
  logic          jogar_q;
  logic [IW-1:0] sorteio_q;
`ifdef JOGO_VIDA_EXTRA_EN
  logic          vida_q, vida_d;
`endif

  logic [IW-1:0] mem_q [N_RODADAS];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] mem_rd;

  logic          evento;
  logic          valido;
  logic [IW-1:0] indice;

  logic          jogar_ed;
  logic [RW-1:0] ultima;
  logic [RW-1:0] addr_ext;
  logic          tempo_esgotado;
  logic [4:0]    prox_erro;
  logic [4:0]    prox_tmo;

  detector_jogada #(
    .N_BOTOES (N_BOTOES),
    .IW       (IW)
  ) u_detector (
    .clk_i    (clock),
    .rst_i    (reset),
    .botoes_i (botoes),
    .evento_o (evento),
    .valido_o (valido),
    .indice_o (indice)
  );

  always_comb begin
    jogar_ed       = jogar & ~jogar_q;
    mem_rd         = mem_q[addr_q];
    ultima         = modo_q[1] ? RW'(N_RODADAS / 2 - 1) : RW'(N_RODADAS - 1);
    addr_ext       = {1'b0, addr_q};
    tempo_esgotado = modo_q[0] && (timer_q == TW'(T_TIMEOUT - 1));
`ifdef JOGO_VIDA_EXTRA_EN
    prox_erro      = vida_q ? StPerdeVida : StFinalErro;
    prox_tmo       = vida_q ? StPerdeVida : StFinalTimeout;
`else
    prox_erro      = StFinalErro;
    prox_tmo       = StFinalTimeout;
`endif
  end

  always_comb begin
    estado_d  = estado_q;
    rodada_d  = rodada_q;
    addr_d    = addr_q;
    timer_d   = timer_q + TW'(1);
    modo_d    = modo_q;
    igual_d   = igual_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
`ifdef JOGO_VIDA_EXTRA_EN
    vida_d    = vida_q;
`endif
    case (estado_q)
      StInicial, StFinalAcerto, StFinalErro, StFinalTimeout: begin
        if (jogar_ed) begin
          estado_d  = StPrepara;
          modo_d    = modo;
          mem_we    = 1'b1;
          mem_wdata = sorteio_q;
        end
      end
      StPrepara: begin
        rodada_d = '0;
        addr_d   = '0;
        igual_d  = 1'b0;
`ifdef JOGO_VIDA_EXTRA_EN
        vida_d   = 1'b1;
`endif
        estado_d = StMostraLed;
      end
      StMostraLed: begin
        if (timer_q == TW'(T_LED - 1)) estado_d = StApagaLed;
      end
      StApagaLed: begin
        if (timer_q == TW'(T_APAGADO - 1)) begin
          if (addr_ext == rodada_q) begin
            addr_d   = '0;
            estado_d = StEsperaJogada;
          end else begin
            addr_d   = addr_q + AW'(1);
            estado_d = StMostraLed;
          end
        end
      end
      StEsperaJogada: begin
        // A press in the expiry cycle takes priority over the timeout.
        if (evento) begin
          igual_d  = valido && (indice == mem_rd);
          estado_d = StCompara;
        end else if (tempo_esgotado) begin
          estado_d = prox_tmo;
        end
      end
      StCompara: begin
        if (!igual_q) begin
          estado_d = prox_erro;
        end else if (addr_ext < rodada_q) begin
          addr_d   = addr_q + AW'(1);
          estado_d = StEsperaJogada;
        end else if (rodada_q == ultima) begin
          estado_d = StFinalAcerto;
        end else begin
          estado_d = StAdicionaJogada;
        end
      end
      StAdicionaJogada: begin
        if (evento) begin
          if (valido) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(rodada_q + RW'(1));
            mem_wdata = indice;
            estado_d  = StProxRodada;
          end else begin
            estado_d  = prox_erro;
          end
        end else if (tempo_esgotado) begin
          estado_d = prox_tmo;
        end
      end
      StProxRodada: begin
        rodada_d = rodada_q + RW'(1);
        addr_d   = '0;
        estado_d = StMostraLed;
      end
`ifdef JOGO_VIDA_EXTRA_EN
      StPerdeVida: begin
        vida_d = 1'b0;
        if (timer_q == TW'(T_LED - 1)) begin
          addr_d   = '0;
          estado_d = StMostraLed;
        end
      end
`endif
      default: estado_d = StInicial;
    endcase
    // Every state change restarts the phase/timeout counter.
    if (estado_d != estado_q) timer_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= StInicial;
      rodada_q  <= '0;
      addr_q    <= '0;
      timer_q   <= '0;
      modo_q    <= '0;
      igual_q   <= 1'b0;
      jogar_q   <= 1'b0;
      sorteio_q <= '0;
`ifdef JOGO_VIDA_EXTRA_EN
      vida_q    <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      rodada_q  <= rodada_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      modo_q    <= modo_d;
      igual_q   <= igual_d;
      jogar_q   <= jogar;
      sorteio_q <= (sorteio_q == IW'(N_BOTOES - 1)) ? '0 : sorteio_q + IW'(1);
`ifdef JOGO_VIDA_EXTRA_EN
      vida_q    <= vida_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    leds = '0;
    case (estado_q)
      StMostraLed:                     leds = Um << mem_rd;
      StEsperaJogada, StAdicionaJogada: leds = botoes;
`ifdef JOGO_VIDA_EXTRA_EN
      StPerdeVida:                     leds = '1;
`endif
      default:                         leds = '0;
    endcase
    pronto    = (estado_q == StFinalAcerto) || (estado_q == StFinalErro) ||
                (estado_q == StFinalTimeout);
    ganhou    = (estado_q == StFinalAcerto);
    perdeu    = (estado_q == StFinalErro) || (estado_q == StFinalTimeout);
    timeout   = (estado_q == StFinalTimeout);
    db_estado = estado_q;
    db_rodada = rodada_q;
    db_igual  = igual_q;
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param: table of whole games with a scoreboard
// of final outcomes, plus hand sequences for timeout timing and reset.
module tb_jogo_memoria_param;
  import jogo_memoria_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned NR = 16;
  localparam int unsigned TL = 4;
  localparam int unsigned TA = 2;
  localparam int unsigned TT = 20;
  localparam int unsigned RW = 5;
  localparam int Bound = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic [1:0]    modo = 2'b00;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          pronto, ganhou, perdeu, timeout, db_igual;
  logic [4:0]    db_estado;
  logic [RW-1:0] db_rodada;

  jogo_memoria_param #(
    .N_BOTOES  (NB),
    .N_RODADAS (NR),
    .T_LED     (TL),
    .T_APAGADO (TA),
    .T_TIMEOUT (TT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .jogar     (jogar),
    .modo      (modo),
    .botoes    (botoes),
    .leds      (leds),
    .pronto    (pronto),
    .ganhou    (ganhou),
    .perdeu    (perdeu),
    .timeout   (timeout),
    .db_estado (db_estado),
    .db_rodada (db_rodada),
    .db_igual  (db_igual)
  );

  always #5 clock = ~clock;

  // Model of the free-running move source: counts clock edges since reset, mod NB.
  int tb_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt + 1) % NB;
  end

  typedef enum int {FNone, FWrong, FInvalid, FTimeout} falha_t;
  typedef struct {
    logic [1:0] modo;
    falha_t     falha;
    int         rodada_falha;
    logic       g;
    logic       p;
    logic       t;
    logic [4:0] est;
    int         rod;
  } vec_t;
  typedef struct {
    logic          g;
    logic          p;
    logic          t;
    logic [4:0]    est;
    logic [RW-1:0] rod;
  } exp_t;

  vec_t vec[6];
  exp_t sb_q[$];
  int   seq[NR];
  int   n_pass = 0;
  int   n_checks = 0;

  task automatic check(input string nome, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nome, got, got, exp, exp);
  endtask

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] u;
    u = 1;
    return u << i;
  endfunction

  // tipo: 0 leds lit, 1 leds dark, 2 state == s, 3 state != s, other pronto
  task automatic espera(input int tipo, input logic [4:0] s, input string nome);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < Bound; k++) begin
      case (tipo)
        0:       ok = (leds != '0);
        1:       ok = (leds == '0);
        2:       ok = (db_estado == s);
        3:       ok = (db_estado != s);
        default: ok = pronto;
      endcase
      if (ok) break;
      @(negedge clock);
    end
    check(nome, int'(ok), 1);
  endtask

  task automatic press(input logic [NB-1:0] b, input int fim);
    botoes = b;
    @(negedge clock);
    check("eco", leds, b);
    @(negedge clock);
    botoes = '0;
    repeat (fim) @(negedge clock);
  endtask

  task automatic start_game(input logic [1:0] m);
    jogar = 1'b0;
    @(negedge clock);
    modo   = m;
    seq[0] = tb_cnt;
    jogar  = 1'b1;
    @(negedge clock);
  endtask

  task automatic playback(input int r);
    int k;
    for (int i = 0; i <= r; i++) begin
      espera(0, '0, "led_aceso");
      check("led_valor", leds, oh(seq[i]));
      k = 0;
      while (leds != '0 && k < 50) begin k++; @(negedge clock); end
      check("t_led", k, TL);
      if (i < r) begin
        k = 0;
        while (leds == '0 && k < 50) begin k++; @(negedge clock); end
        check("t_apagado", k, TA);
      end
    end
  endtask

  task automatic check_zerado(input string nome);
    check({nome, "_leds"}, leds, 0);
    check({nome, "_pronto"}, pronto, 0);
    check({nome, "_ganhou"}, ganhou, 0);
    check({nome, "_perdeu"}, perdeu, 0);
    check({nome, "_timeout"}, timeout, 0);
    check({nome, "_estado"}, db_estado, StInicial);
    check({nome, "_rodada"}, db_rodada, 0);
    check({nome, "_igual"}, db_igual, 0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    jogar = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic play_game(input int idx);
    vec_t v;
    exp_t e;
    int   r, goal, faltas;
    bit   fim;
    v = vec[idx];
    start_game(v.modo);
    e.g = v.g; e.p = v.p; e.t = v.t; e.est = v.est; e.rod = RW'(v.rod);
    sb_q.push_back(e);
    goal   = v.modo[1] ? NR / 2 : NR;
    r      = 0;
    faltas = 0;
    fim    = 1'b0;
    while (!fim) begin
      playback(r);
      espera(2, StEsperaJogada, "espera");
      if (v.falha != FNone && r == v.rodada_falha) begin
        case (v.falha)
          FWrong: begin
            for (int i = 0; i < r; i++) press(oh(seq[i]), 2);
            press(oh((seq[r] + 1) % NB), 2);
          end
          FInvalid: press(4'b0011, 2);
          default:  espera(3, StEsperaJogada, "sai_espera");
        endcase
        faltas++;
`ifdef JOGO_VIDA_EXTRA_EN
        if (faltas == 1) begin
          check("perde_vida", db_estado, StPerdeVida);
          check("vida_leds", leds, 4'hF);
          espera(2, StMostraLed, "replay");
          continue;
        end
`endif
        check("estado_falha", db_estado, v.est);
        fim = 1'b1;
      end else begin
        for (int i = 0; i <= r; i++) press(oh(seq[i]), 2);
        if (r == goal - 1) begin
          fim = 1'b1;
        end else begin
          check("sem_vitoria", ganhou, 0);
          seq[r + 1] = r % NB;
          press(oh(seq[r + 1]), 0);
          r++;
        end
      end
    end
    espera(4, '0, "pronto");
    if (sb_q.size() == 0) begin
      check("sb_vazio", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("sb_ganhou", ganhou, e.g);
      check("sb_perdeu", perdeu, e.p);
      check("sb_timeout", timeout, e.t);
      check("sb_estado", db_estado, e.est);
      check("sb_rodada", db_rodada, e.rod);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    vec[0] = '{2'b00, FNone,    0, 1'b1, 1'b0, 1'b0, StFinalAcerto,  15};
    vec[1] = '{2'b10, FNone,    0, 1'b1, 1'b0, 1'b0, StFinalAcerto,   7};
    vec[2] = '{2'b00, FWrong,   2, 1'b0, 1'b1, 1'b0, StFinalErro,     2};
    vec[3] = '{2'b01, FTimeout, 1, 1'b0, 1'b1, 1'b1, StFinalTimeout,  1};
    vec[4] = '{2'b00, FInvalid, 0, 1'b0, 1'b1, 1'b0, StFinalErro,     0};
    vec[5] = '{2'b11, FNone,    0, 1'b1, 1'b0, 1'b0, StFinalAcerto,   7};

    #2 reset = 1'b1;
    #1 check_zerado("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) play_game(i);

    // Timeout fires exactly TT cycles after entering the wait state.
    apply_reset();
    start_game(2'b01);
    playback(0);
    espera(2, StEsperaJogada, "espera_tmo");
    k = 0;
    while (db_estado == StEsperaJogada && k < TT + 10) begin k++; @(negedge clock); end
    check("t_timeout", k, TT);
`ifdef JOGO_VIDA_EXTRA_EN
    check("tmo_vida", db_estado, StPerdeVida);
    k = 0;
    while (leds == 4'hF && k < 50) begin k++; @(negedge clock); end
    check("t_vida", k, TL);
    check("vida_replay_estado", db_estado, StMostraLed);
    check("vida_replay_led", leds, oh(seq[0]));
`else
    check("tmo_estado", db_estado, StFinalTimeout);
    check("tmo_flag", timeout, 1);
`endif

    // Without modo[0] the wait never expires; then reset during playback.
    apply_reset();
    start_game(2'b00);
    playback(0);
    espera(2, StEsperaJogada, "espera_sem_tmo");
    repeat (3 * TT) @(negedge clock);
    check("sem_tmo_estado", db_estado, StEsperaJogada);
    check("sem_tmo_pronto", pronto, 0);
    press(oh(seq[0]), 2);
    seq[1] = 0;
    press(oh(seq[1]), 0);
    espera(0, '0, "led_antes_reset");
    reset = 1'b1;
    #1 check_zerado("reset_meio");
    jogar = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
